// File: rtl/dds_ddc_center_round_accum.sv
// Rounds/saturates signed products to 18 bits, then sums non-overlapping windows of N samples.
// Latency 2 enabled cycles; ce=0 freezes everything, no backpressure.
module dds_ddc_center_round_accum #(
  parameter int DIN_WIDTH = 34,
  parameter int SHIFT     = 16,
  parameter int LOG2_N    = 3
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                ce,
  input  logic                                din_valid,
  input  logic [DIN_WIDTH-1:0]                din,
  input  logic                                sync,
  input  logic                                clr_sat,
  output logic                                dout_valid,
  output logic [DIN_WIDTH-SHIFT+LOG2_N-1:0]   dout,
  output logic                                sat_flag
);

  localparam int RW = DIN_WIDTH - SHIFT;
  localparam int DW = RW + LOG2_N;

  logic signed [DIN_WIDTH:0] w_half;
  logic signed [DIN_WIDTH:0] w_rnd_full;
  logic        [RW:0]        w_rnd;
  logic                      w_ovf;
  logic        [RW-1:0]      w_rnd_sat;

  logic [RW-1:0]     r_s1;
  logic              r_s1_v;
  logic              r_s1_sat;
  logic              r_s1_sync;
  logic [LOG2_N-1:0] r_cnt;
  logic [DW-1:0]     r_acc;
  logic [DW-1:0]     r_dout;
  logic              r_dout_valid;
  logic              r_sat_flag;

  logic [DW-1:0]     w_s1_ext;
  logic [LOG2_N-1:0] w_cnt_eff;
  logic              w_first;
  logic              w_last;
  logic [DW-1:0]     w_sum;

  assign w_half     = {{(DIN_WIDTH-SHIFT+1){1'b0}}, 1'b1, {(SHIFT-1){1'b0}}};
  assign w_rnd_full = $signed({din[DIN_WIDTH-1], din}) + w_half;
  // Taking the top bits is the arithmetic shift; one guard bit exposes overflow.
  assign w_rnd      = w_rnd_full[DIN_WIDTH:SHIFT];
  assign w_ovf      = w_rnd[RW] ^ w_rnd[RW-1];
  assign w_rnd_sat  = w_ovf ? {w_rnd[RW], {(RW-1){~w_rnd[RW]}}} : w_rnd[RW-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1      <= '0;
      r_s1_v    <= 1'b0;
      r_s1_sat  <= 1'b0;
      r_s1_sync <= 1'b0;
    end else if (ce) begin
      r_s1      <= w_rnd_sat;
      r_s1_v    <= din_valid;
      r_s1_sat  <= din_valid & w_ovf;
      r_s1_sync <= sync;
    end
  end

  // A pipelined sync makes this cycle look like the start of a fresh window.
  assign w_s1_ext  = {{LOG2_N{r_s1[RW-1]}}, r_s1};
  assign w_cnt_eff = r_s1_sync ? '0 : r_cnt;
  assign w_first   = (w_cnt_eff == '0);
  assign w_last    = &w_cnt_eff;
  assign w_sum     = w_first ? w_s1_ext : (r_acc + w_s1_ext);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt        <= '0;
      r_acc        <= '0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_sat_flag   <= 1'b0;
    end else if (ce) begin
      r_dout_valid <= 1'b0;
      if (r_s1_v) begin
        r_acc <= w_sum;
        if (w_last) begin
          r_cnt        <= '0;
          r_dout       <= w_sum;
          r_dout_valid <= 1'b1;
        end else begin
          r_cnt <= w_cnt_eff + 1'b1;
        end
      end else begin
        r_cnt <= w_cnt_eff;
      end
      if (r_s1_v && r_s1_sat) begin
        r_sat_flag <= 1'b1;
      end else if (clr_sat) begin
        r_sat_flag <= 1'b0;
      end
    end
  end

  assign dout_valid = r_dout_valid;
  assign dout       = r_dout;
  assign sat_flag   = r_sat_flag;

endmodule

// File: tb/tb_dds_ddc_center_round_accum.sv
// Bench for dds_ddc_center_round_accum: directed scenarios plus random traffic,
// every cycle compared against a window-sum reference model.
module tb_dds_ddc_center_round_accum;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               ce = 1'b0;
  logic               din_valid = 1'b0;
  logic [33:0]        din = '0;
  logic               sync = 1'b0;
  logic               clr_sat = 1'b0;
  logic               dout_valid;
  logic signed [20:0] dout;
  logic               sat_flag;

  int total = 0;
  int bad   = 0;
  int pulses = 0;

  // reference model state
  int     m_cnt = 0;
  longint m_sum = 0;
  bit     pend_v = 0;
  longint pend_val = 0;
  bit     pend_sat = 0;
  bit     e_vld = 0;
  longint e_dout = 0;
  bit     e_sat = 0;

  dds_ddc_center_round_accum dut (
    .clk        (clk),
    .reset      (reset),
    .ce         (ce),
    .din_valid  (din_valid),
    .din        (din),
    .sync       (sync),
    .clr_sat    (clr_sat),
    .dout_valid (dout_valid),
    .dout       (dout),
    .sat_flag   (sat_flag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic longint round_sat(input logic [33:0] d, output bit s);
    longint x;
    longint r;
    x = longint'($signed(d));
    r = (x + 32768) >>> 16;
    s = 0;
    if (r > 131071) begin r = 131071; s = 1; end
    if (r < -131072) begin r = -131072; s = 1; end
    return r;
  endfunction

  task automatic step(input bit c, input bit v, input logic [33:0] d, input bit s,
                      input bit clr, input bit rst);
    bit     sb;
    longint r;
    reset = rst; ce = c; din_valid = v; din = d; sync = s; clr_sat = clr;
    @(posedge clk);
    #1;
    if (rst) begin
      m_cnt = 0; m_sum = 0; pend_v = 0; pend_val = 0; pend_sat = 0;
      e_vld = 0; e_dout = 0; e_sat = 0;
    end else if (c) begin
      e_vld = pend_v;
      if (pend_v) e_dout = pend_val;
      e_sat = pend_sat ? 1'b1 : (clr ? 1'b0 : e_sat);
      pend_v = 0; pend_sat = 0;
      if (s) begin m_cnt = 0; m_sum = 0; end
      if (v) begin
        r = round_sat(d, sb);
        pend_sat = sb;
        m_sum += r;
        m_cnt++;
        if (m_cnt == 8) begin
          pend_v = 1; pend_val = m_sum; m_cnt = 0; m_sum = 0;
        end
      end
    end
    if (dout_valid === 1'b1 && c && !rst) pulses++;
    chk("dout_valid", dout_valid, e_vld);
    chk("dout", dout, e_dout);
    chk("sat_flag", sat_flag, e_sat);
  endtask

  task automatic samples(input int n, input logic [33:0] d);
    for (int i = 0; i < n; i++) step(1, 1, d, 0, 0, 0);
  endtask

  initial begin
    logic [33:0] rv [4];
    longint      rx [4];
    logic [63:0] tmp;
    logic [33:0] d;
    bit c, v, s, clr, rst;

    rv[0] = 34'd32768;          rx[0] = 8;
    rv[1] = 34'd32767;          rx[1] = 0;
    rv[2] = 34'h3_FFFF_8000;    rx[2] = 0;
    rv[3] = 34'h3_FFFF_7FFF;    rx[3] = -8;

    step(1, 0, 0, 0, 0, 1);
    step(0, 1, 34'h1_2345_6789, 1, 0, 1);
    chk("reset_dout", dout, 0);
    chk("reset_vld", dout_valid, 0);

    // basic window
    pulses = 0;
    samples(8, 34'(3 << 16));
    chk("basic_early", dout_valid, 0);
    step(1, 0, 0, 0, 0, 0);
    chk("basic_dout", dout, 24);
    chk("basic_vld", dout_valid, 1);
    chk("basic_sat", sat_flag, 0);
    step(1, 0, 0, 0, 0, 0);
    chk("basic_pulse_once", dout_valid, 0);

    // rounding windows
    for (int k = 0; k < 4; k++) begin
      samples(8, rv[k]);
      step(1, 0, 0, 0, 0, 0);
      chk("round_dout", dout, rx[k]);
    end

    // saturation and clear
    samples(8, 34'h1_FFFF_FFFF);
    step(1, 0, 0, 0, 0, 0);
    chk("sat_dout", dout, 1048568);
    chk("sat_flag_set", sat_flag, 1);
    step(1, 0, 0, 0, 1, 0);
    chk("sat_flag_clr", sat_flag, 0);
    samples(8, 34'h2_0000_0000);
    step(1, 0, 0, 0, 0, 0);
    chk("neg_dout", dout, -1048576);
    chk("neg_sat", sat_flag, 0);

    // sync mid-window
    pulses = 0;
    samples(3, 34'(1 << 16));
    step(1, 1, 34'(5 << 16), 1, 0, 0);
    samples(7, 34'(1 << 16));
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    chk("sync_dout", dout, 12);
    chk("sync_pulses", pulses, 1);

    // ce stall
    pulses = 0;
    samples(4, 34'(2 << 16));
    for (int i = 0; i < 4; i++) step(0, 1, 34'h1_FFFF_FFFF, 1, 1, 0);
    samples(4, 34'(2 << 16));
    chk("stall_early", dout_valid, 0);
    step(1, 0, 0, 0, 0, 0);
    chk("stall_dout", dout, 16);
    chk("stall_pulses", pulses, 1);

    // reset mid-window
    pulses = 0;
    samples(5, 34'(9 << 16));
    step(1, 1, 34'(9 << 16), 0, 0, 1);
    chk("rst_mid_dout", dout, 0);
    chk("rst_mid_sat", sat_flag, 0);
    samples(8, 34'(2 << 16));
    step(1, 0, 0, 0, 0, 0);
    chk("rst_mid_result", dout, 16);
    chk("rst_mid_pulses", pulses, 1);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      c   = ($urandom_range(0, 9) != 0);
      v   = ($urandom_range(0, 3) != 0);
      s   = ($urandom_range(0, 29) == 0);
      clr = ($urandom_range(0, 19) == 0);
      rst = ($urandom_range(0, 149) == 0);
      tmp = {$urandom(), $urandom()};
      case ($urandom_range(0, 3))
        0: d = tmp[33:0];
        1: d = 34'h1_FFFF_FFFF - 34'(tmp[17:0]);
        2: d = 34'h2_0000_0000 + 34'(tmp[17:0]);
        default: d = 34'($signed(tmp[20:0]));
      endcase
      step(c, v, d, s, clr, rst);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
